// File: rtl/rtc_bus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rtc_bus_ctrl_if                                                  |
// | Brief   : Request and pin bundle between the RTC sequencer, the bus        |
// |           controller and the RTC chip pads.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface rtc_bus_ctrl_if #(
  parameter int DW = 8
);
  logic          iniciar;
  logic          escribe;
  logic [DW-1:0] direccion;
  logic [DW-1:0] dato;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          CS;
  logic          AD;
  logic          RD;
  logic          WR;
  logic [DW-1:0] dato_leido;
  logic          ocupado;
  // Transaction-complete strobe; "final" itself is a reserved word.
  logic          final_pulse;
  logic          error;

  modport master (
    input  iniciar, escribe, direccion, dato, data_in,
    output data_out, data_oe, CS, AD, RD, WR, dato_leido, ocupado, final_pulse, error
  );

  modport slave (
    output iniciar, escribe, direccion, dato, data_in,
    input  data_out, data_oe, CS, AD, RD, WR, dato_leido, ocupado, final_pulse, error
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rtc_bus_ctrl                                                     |
// | Brief   : One multiplexed address/data transaction per request with        |
// |           programmable strobe/gap lengths. Optional write readback and     |
// |           compare is enabled by defining RTC_READBACK_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rtc_bus_ctrl #(
  parameter int DW      = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2
) (
  input  wire            clk,
  input  wire            reset,
  rtc_bus_ctrl_if.master bus
);

`ifdef RTC_READBACK_EN
  localparam bit c_READBACK = 1'b1;
`else
  localparam bit c_READBACK = 1'b0;
`endif

  localparam int                 c_CNT_MAX  = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int                 c_CNT_W    = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_LD_PULSE = c_CNT_W'(T_PULSE - 1);
  localparam logic [c_CNT_W-1:0] c_LD_GAP   = c_CNT_W'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_GAP = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_GAP = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_escribe;
  logic [DW-1:0]        r_dir;
  logic [DW-1:0]        r_dato;
  logic                 r_rb;
  logic                 r_cs;
  logic                 r_ad;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_oe;
  logic [DW-1:0]        r_dout;
  logic [DW-1:0]        r_leido;
  logic                 r_ocupado;
  logic                 r_final;
  logic                 r_error;

  // The readback pass of a write is carried out as a read.
  logic                 w_wr_now;
  logic                 w_cnt_zero;

  assign w_wr_now   = r_escribe & ~r_rb;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_escribe <= 1'b0;
      r_dir     <= '0;
      r_dato    <= '0;
      r_rb      <= 1'b0;
      r_cs      <= 1'b1;
      r_ad      <= 1'b1;
      r_rd      <= 1'b1;
      r_wr      <= 1'b1;
      r_oe      <= 1'b0;
      r_dout    <= '0;
      r_leido   <= '0;
      r_ocupado <= 1'b0;
      r_final   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_final <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iniciar) begin
            r_state   <= S_ADDR;
            r_cnt     <= c_LD_PULSE;
            r_escribe <= bus.escribe;
            r_dir     <= bus.direccion;
            r_dato    <= bus.dato;
            r_rb      <= 1'b0;
            r_error   <= 1'b0;
            r_cs      <= 1'b0;
            r_ad      <= 1'b0;
            r_wr      <= 1'b0;
            r_dout    <= bus.direccion;
            r_oe      <= 1'b1;
            r_ocupado <= 1'b1;
          end
        end

        S_ADDR: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_ADDR_GAP;
            r_cnt   <= c_LD_GAP;
            r_ad    <= 1'b1;
            r_wr    <= 1'b1;
            r_oe    <= 1'b0;
          end
        end

        S_ADDR_GAP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_DATA;
            r_cnt   <= c_LD_PULSE;
            if (w_wr_now) begin
              r_wr   <= 1'b0;
              r_dout <= r_dato;
              r_oe   <= 1'b1;
            end else begin
              r_rd <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_DATA_GAP;
            r_cnt   <= c_LD_GAP;
            r_wr    <= 1'b1;
            r_rd    <= 1'b1;
            r_oe    <= 1'b0;
            // Capture on the edge that closes the last RD-low cycle.
            if (!w_wr_now) begin
              r_leido <= bus.data_in;
            end
          end
        end

        S_DATA_GAP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (c_READBACK && r_escribe && !r_rb) begin
            r_state <= S_ADDR;
            r_rb    <= 1'b1;
            r_cnt   <= c_LD_PULSE;
            r_ad    <= 1'b0;
            r_wr    <= 1'b0;
            r_dout  <= r_dir;
            r_oe    <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_cs    <= 1'b1;
            r_final <= 1'b1;
            if (r_rb) begin
              r_error <= (r_leido != r_dato);
            end
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_ocupado <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_cs      <= 1'b1;
          r_ad      <= 1'b1;
          r_rd      <= 1'b1;
          r_wr      <= 1'b1;
          r_oe      <= 1'b0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = r_dout;
  assign bus.data_oe     = r_oe;
  assign bus.CS          = r_cs;
  assign bus.AD          = r_ad;
  assign bus.RD          = r_rd;
  assign bus.WR          = r_wr;
  assign bus.dato_leido  = r_leido;
  assign bus.ocupado     = r_ocupado;
  assign bus.final_pulse = r_final;
  assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rtc_bus_ctrl                                                  |
// | Brief   : Randomized self-checking bench for rtc_bus_ctrl against a        |
// |           cycle-indexed timeline model (honours RTC_READBACK_EN).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rtc_bus_ctrl;
  localparam int DW      = 8;
  localparam int T_PULSE = 4;
  localparam int T_GAP   = 2;
  localparam int c_H     = 2 * (T_PULSE + T_GAP);

`ifdef RTC_READBACK_EN
  localparam bit c_RB = 1'b1;
`else
  localparam bit c_RB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] exp_dout;
  logic [DW-1:0] exp_leido;
  logic          exp_err;

  rtc_bus_ctrl_if #(.DW(DW)) bus_if ();

  rtc_bus_ctrl #(.DW(DW), .T_PULSE(T_PULSE), .T_GAP(T_GAP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // {CS, AD, RD, WR, data_oe, ocupado, final, error}
  function automatic logic [7:0] ctl_vec();
    return {bus_if.CS, bus_if.AD, bus_if.RD, bus_if.WR, bus_if.data_oe,
            bus_if.ocupado, bus_if.final_pulse, bus_if.error};
  endfunction

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, ctl_vec(), {7'b1111_000, exp_err});
      check({tag, "_dout"}, bus_if.data_out, exp_dout);
      check({tag, "_leido"}, bus_if.dato_leido, exp_leido);
      bus_if.data_in = DW'($urandom);
    end
  endtask

  // Called at a negedge with the DUT idle; the next posedge is the sampling edge k.
  task automatic run_txn(input string tag, input bit wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] dat, input logic [DW-1:0] rdval, input bit hold);
    int halves;
    int done;
    halves = (wr && c_RB) ? 2 : 1;
    done   = 1 + halves * c_H;
    bus_if.escribe   = wr;
    bus_if.direccion = addr;
    bus_if.dato      = dat;
    bus_if.iniciar   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.iniciar   = hold;
    bus_if.escribe   = 1'($urandom);
    bus_if.direccion = DW'($urandom);
    bus_if.dato      = DW'($urandom);
    for (int j = 1; j <= done + 1; j++) begin
      logic cs, ad, rd, wrs, oe, oc, fn;
      bit   rd_last;
      int   jj;
      @(negedge clk);
      cs = 1'b1; ad = 1'b1; rd = 1'b1; wrs = 1'b1; oe = 1'b0; oc = 1'b1; fn = 1'b0;
      rd_last = 1'b0;
      if (j == 1) exp_err = 1'b0;
      if (j < done) begin
        jj = (j - 1) % c_H + 1;
        cs = 1'b0;
        if (jj <= T_PULSE) begin
          ad = 1'b0; wrs = 1'b0; oe = 1'b1; exp_dout = addr;
        end else if (jj > T_PULSE + T_GAP && jj <= 2 * T_PULSE + T_GAP) begin
          if (wr && (j <= c_H)) begin
            wrs = 1'b0; oe = 1'b1; exp_dout = dat;
          end else begin
            rd = 1'b0; rd_last = (jj == 2 * T_PULSE + T_GAP);
          end
        end
      end else if (j == done) begin
        fn = 1'b1;
        if (halves == 2) exp_err = (rdval != dat);
      end else begin
        oc = 1'b0;
      end
      check({tag, "_ctl"}, ctl_vec(), {cs, ad, rd, wrs, oe, oc, fn, exp_err});
      check({tag, "_dout"}, bus_if.data_out, exp_dout);
      check({tag, "_leido"}, bus_if.dato_leido, exp_leido);
      bus_if.data_in = rd ? DW'($urandom) : rdval;
      if (rd_last) exp_leido = rdval;
    end
  endtask

  initial begin
    bit            wr;
    bit            hold;
    logic [DW-1:0] a, d, r;
    bus_if.iniciar   = 1'b0;
    bus_if.escribe   = 1'b0;
    bus_if.direccion = '0;
    bus_if.dato      = '0;
    bus_if.data_in   = '0;
    exp_dout  = '0;
    exp_leido = '0;
    exp_err   = 1'b0;

    idle_cycles(2, "in_reset");
    reset = 1'b1;
    idle_cycles(20, "post_reset");

    run_txn("wr21", 1'b1, 8'h21, 8'h45, 8'h45, 1'b0);
    idle_cycles(2, "idle_a");
    run_txn("rdF0", 1'b0, 8'hF0, 8'h00, 8'h5A, 1'b0);
    check("read_capture", bus_if.dato_leido, 32'h5A);

    run_txn("hold1", 1'b1, 8'h12, 8'h9C, 8'h00, 1'b1);
    run_txn("hold2", 1'b0, 8'h34, 8'h00, 8'hA7, 1'b0);
    idle_cycles(1, "idle_b");

    // Asynchronous reset in the middle of a write data strobe.
    bus_if.escribe   = 1'b1;
    bus_if.direccion = 8'h7E;
    bus_if.dato      = 8'hC3;
    bus_if.iniciar   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.iniciar = 1'b0;
    repeat (T_PULSE + T_GAP + 1) @(posedge clk);
    #2;
    check("pre_rst_wr", {bus_if.CS, bus_if.WR, bus_if.data_oe}, 3'b001);
    reset = 1'b0;
    #1;
    exp_dout  = '0;
    exp_leido = '0;
    exp_err   = 1'b0;
    check("async_rst", {ctl_vec(), bus_if.data_out}, {8'b1111_0000, 8'h00});
    idle_cycles(3, "rst_hold");
    reset = 1'b1;
    idle_cycles(2, "rst_rel");
    run_txn("after_rst", 1'b1, 8'h55, 8'hAA, 8'hAA, 1'b0);

`ifdef RTC_READBACK_EN
    run_txn("rb_ok", 1'b1, 8'h40, 8'h33, 8'h33, 1'b0);
    check("rb_ok_err", bus_if.error, 32'h0);
    run_txn("rb_bad", 1'b1, 8'h40, 8'h33, 8'h32, 1'b0);
    check("rb_bad_err", bus_if.error, 32'h1);
`endif

    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = DW'($urandom);
      d    = DW'($urandom);
      r    = ($urandom_range(0, 1) == 1) ? d : DW'($urandom);
      hold = (t != 39) && ($urandom_range(0, 3) == 0);
      run_txn("rand", wr, a, d, r, hold);
      if (!hold) idle_cycles($urandom_range(0, 2), "rand_idle");
    end
    bus_if.iniciar = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Parametrised controller for the RTC's multiplexed address/data bus, and the next generation of the RTC output controller. For each request it runs one complete bus transaction, a write or a read, with programmable strobe and gap lengths. It drives a tristate data bus and captures read data. It sits between the RTC register-access sequencer and the RTC chip pins.

## Interface
Parameters:
- DW, 8, width of address and data bus.
- T_PULSE, 4, clock cycles each strobe (WR or RD) is held low; must be ≥1.
- T_GAP, 2, clock cycles all strobes are high after each strobe; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  transaction request, sampled only in IDLE.
- escribe  in  1  1 = write, 0 = read; latched at start.
- direccion  in  DW  RTC register address; latched at start.
- dato  in  DW  write data; latched at start.
- data_in  in  DW  bus value from pad, sampled on reads.
- data_out  out  DW  bus value to pad.
- data_oe  out  1  pad output enable; 1 = controller drives the bus.
- CS  out  1  chip select, active-low.
- AD  out  1  address/data select; 0 = address phase.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- dato_leido  out  DW  last captured read data.
- ocupado  out  1  high whenever state ≠ IDLE.
- final  out  1  one-cycle pulse when the transaction completes.
- error  out  1  readback mismatch flag; exists only with RTC_READBACK_EN.

## Operation
- States and transitions:
  - IDLE → ADDR when iniciar=1.
  - ADDR → ADDR_GAP.
  - ADDR_GAP → DATA.
  - DATA → DATA_GAP.
  - DATA_GAP → DONE.
  - DONE → IDLE.
- ADDR: CS=0, AD=0, WR=0, data_out=direccion, data_oe=1.
- ADDR_GAP: CS=0, AD=1, WR=1, RD=1, data_oe=0.
- DATA, write: CS=0, AD=1, WR=0, data_out=dato, data_oe=1.
- DATA, read: CS=0, AD=1, RD=0, data_oe=0.
- DATA_GAP: CS=0, all strobes high, data_oe=0.
- DONE: CS=1, final=1.
- IDLE: CS=1, AD=1, RD=1, WR=1, data_oe=0.
- A single down-counter sized $clog2(max(T_PULSE,T_GAP)+1) times every phase.
- escribe, direccion and dato are latched on the IDLE→ADDR edge. Input changes during a transaction have no effect.
- Read capture: data_in is registered into dato_leido on the edge that ends the last RD-low cycle. dato_leido holds until the next read capture. Writes do not alter it.
- iniciar is level-sampled. If it is still high in IDLE after DONE, a new transaction starts, with at least one IDLE cycle between transactions.
- data_out holds its last value when data_oe=0.

## Timing
- Reset values: CS=1, AD=1, RD=1, WR=1, data_oe=0, data_out=0, dato_leido=0, ocupado=0, final=0, error=0. State is IDLE.
- Reset asserted mid-transaction forces these values immediately (asynchronously). The latched request is discarded and no final pulse is produced.
- Cycle numbering: iniciar is sampled high at edge k.
- Address phase: strobes low during cycles k+1 … k+T_PULSE.
- Address gap: T_GAP cycles.
- Data strobe: T_PULSE cycles.
- Data gap: T_GAP cycles.
- final=1 for exactly the single cycle k+1+2·(T_PULSE+T_GAP). With defaults this is k+13.
- CS is low for exactly 2·(T_PULSE+T_GAP) contiguous cycles per transaction.
- WR and RD are never low in the same cycle. data_oe=1 only while AD=0 or WR=0.

## Configuration
- RTC_READBACK_EN defined:
  - After a write's DATA_GAP, the FSM re-runs ADDR, ADDR_GAP, DATA (as a read) and DATA_GAP to the same address, then enters DONE.
  - error is registered in DONE as (captured value ≠ latched dato). It holds until the next transaction starts.
  - Write-with-readback final pulse comes at k+1+4·(T_PULSE+T_GAP).
  - Reads are unchanged.
  - dato_leido is updated by the readback.
- RTC_READBACK_EN undefined:
  - No readback phase.
  - error is tied to 0.
  - All transactions follow the base timing.

## Test plan
- Reset release, no request: all outputs hold reset values for 20 cycles; ocupado=0.
- Write: direccion=8'h21, dato=8'h45, escribe=1, iniciar pulsed one cycle, defaults.
  - data_out=8'h21 with AD=0 and WR=0 for 4 cycles.
  - Then a 2-cycle gap.
  - Then data_out=8'h45 with WR=0 for 4 cycles.
  - final pulses once, 13 cycles after the sampling edge.
- Read: direccion=8'hF0, escribe=0, data_in=8'h5A during the RD-low window.
  - dato_leido=8'h5A.
  - data_oe=0 throughout the data phase.
  - RD low for exactly 4 cycles.
- iniciar held high across two transactions: two final pulses, with at least one IDLE cycle (CS=1, ocupado=0) between them.
- reset driven low during the data phase of a write: CS, WR and data_oe return to reset values with no clock edge needed; no final pulse; the next request runs normally.
- With RTC_READBACK_EN:
  - Write 8'h33 with data_in=8'h33: final at k+25, error=0.
  - Repeat with data_in=8'h32: error=1.
